// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: PC, I-mem request, 2-entry skid buffer and IF/ID register.
// Redirects from EX flush everything in flight and refetch from the target.
module risc_toy_fetch #(
    parameter logic [29:0] RESET_ADDR = 30'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IREQ,
    output logic [29:0] IADDR,
    input  logic [31:0] INSTR,
    input  logic        STALL,
    input  logic        REDIR,
    input  logic [29:0] REDIR_ADDR,
    output logic        FI_VALID,
    output logic [31:0] FI_INSTR,
    output logic [29:0] FI_IADDR,
    output logic [29:0] FI_NPC
);

    logic [29:0]       pc_q, pc_d;
    logic              inf_q, inf_d;
    logic [29:0]       inf_addr_q, inf_addr_d;
    logic [1:0][31:0]  buf_instr_q, buf_instr_d;
    logic [1:0][29:0]  buf_addr_q, buf_addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              fi_valid_q, fi_valid_d;
    logic [31:0]       fi_instr_q, fi_instr_d;
    logic [29:0]       fi_iaddr_q, fi_iaddr_d;
    logic [29:0]       fi_npc_q, fi_npc_d;

    logic [2:0]        occupancy;
    logic              issue;
    logic              fi_free;

    // Slots already claimed: buffered entries plus the response still on its way.
    assign occupancy = {1'b0, cnt_q} + {2'b00, inf_q};
    assign issue     = !RST && !REDIR && (occupancy < 3'd2);
    assign fi_free   = !fi_valid_q || !STALL;

    assign IREQ     = issue;
    assign IADDR    = pc_q;
    assign FI_VALID = fi_valid_q;
    assign FI_INSTR = fi_instr_q;
    assign FI_IADDR = fi_iaddr_q;
    assign FI_NPC   = fi_npc_q;

    always_comb begin
        pc_d        = issue ? pc_q + 30'd1 : pc_q;
        inf_d       = issue;
        inf_addr_d  = issue ? pc_q : inf_addr_q;
        buf_instr_d = buf_instr_q;
        buf_addr_d  = buf_addr_q;
        cnt_d       = cnt_q;
        fi_valid_d  = fi_valid_q;
        fi_instr_d  = fi_instr_q;
        fi_iaddr_d  = fi_iaddr_q;
        fi_npc_d    = fi_npc_q;

        if (REDIR) begin
            pc_d       = REDIR_ADDR;
            inf_d      = 1'b0;
            cnt_d      = 2'd0;
            fi_valid_d = 1'b0;
            fi_instr_d = 32'h0;
        end else if (fi_free) begin
            if (cnt_q != 2'd0) begin
                fi_valid_d     = 1'b1;
                fi_instr_d     = buf_instr_q[0];
                fi_iaddr_d     = buf_addr_q[0];
                fi_npc_d       = buf_addr_q[0] + 30'd1;
                buf_instr_d[0] = buf_instr_q[1];
                buf_addr_d[0]  = buf_addr_q[1];
                // A response arriving during a pop queues behind whatever remains.
                if (inf_q) begin
                    if (cnt_q == 2'd1) begin
                        buf_instr_d[0] = INSTR;
                        buf_addr_d[0]  = inf_addr_q;
                    end else begin
                        buf_instr_d[1] = INSTR;
                        buf_addr_d[1]  = inf_addr_q;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end else if (inf_q) begin
                fi_valid_d = 1'b1;
                fi_instr_d = INSTR;
                fi_iaddr_d = inf_addr_q;
                fi_npc_d   = inf_addr_q + 30'd1;
            end else begin
                fi_valid_d = 1'b0;
                fi_instr_d = 32'h0;
            end
        end else if (inf_q) begin
            if (cnt_q == 2'd0) begin
                buf_instr_d[0] = INSTR;
                buf_addr_d[0]  = inf_addr_q;
            end else begin
                buf_instr_d[1] = INSTR;
                buf_addr_d[1]  = inf_addr_q;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q        <= RESET_ADDR;
            inf_q       <= 1'b0;
            inf_addr_q  <= 30'h0;
            buf_instr_q <= '0;
            buf_addr_q  <= '0;
            cnt_q       <= 2'd0;
            fi_valid_q  <= 1'b0;
            fi_instr_q  <= 32'h0;
            fi_iaddr_q  <= 30'h0;
            fi_npc_q    <= 30'h0;
        end else begin
            pc_q        <= pc_d;
            inf_q       <= inf_d;
            inf_addr_q  <= inf_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_addr_q  <= buf_addr_d;
            cnt_q       <= cnt_d;
            fi_valid_q  <= fi_valid_d;
            fi_instr_q  <= fi_instr_d;
            fi_iaddr_q  <= fi_iaddr_d;
            fi_npc_q    <= fi_npc_d;
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Scoreboard bench for risc_toy_fetch: stall/skid, redirect, reset and PC-wrap scenarios.
// Memory returns {2'b0, addr}; u_wrap exercises the 30-bit PC wrap from 3FFFFFFF.
module tb_risc_toy_fetch;

    logic        CLK;
    logic        RST;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        STALL;
    logic        REDIR;
    logic [29:0] REDIR_ADDR;
    logic        FI_VALID;
    logic [31:0] FI_INSTR;
    logic [29:0] FI_IADDR;
    logic [29:0] FI_NPC;

    logic        rst_w;
    logic        ireq_w;
    logic [29:0] iaddr_w;
    logic [31:0] instr_w;
    logic        stall_w;
    logic        redir_w;
    logic [29:0] redir_addr_w;
    logic        fi_valid_w;
    logic [31:0] fi_instr_w;
    logic [29:0] fi_iaddr_w;
    logic [29:0] fi_npc_w;

    int          n_total;
    int          n_pass;
    logic [29:0] exp_q[$];
    logic        prev_valid;
    logic        prev_stall;

    risc_toy_fetch #(.RESET_ADDR(30'h0000_0000)) u_dut (
        .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .STALL(STALL), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR),
        .FI_VALID(FI_VALID), .FI_INSTR(FI_INSTR), .FI_IADDR(FI_IADDR), .FI_NPC(FI_NPC)
    );

    risc_toy_fetch #(.RESET_ADDR(30'h3FFF_FFFF)) u_wrap (
        .CLK(CLK), .RST(rst_w), .IREQ(ireq_w), .IADDR(iaddr_w), .INSTR(instr_w),
        .STALL(stall_w), .REDIR(redir_w), .REDIR_ADDR(redir_addr_w),
        .FI_VALID(fi_valid_w), .FI_INSTR(fi_instr_w), .FI_IADDR(fi_iaddr_w), .FI_NPC(fi_npc_w)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One-cycle-latency memory; without a request the read data simply holds (stale).
    always @(posedge CLK) begin
        if (IREQ) INSTR <= {2'b00, IADDR};
        if (ireq_w) instr_w <= {2'b00, iaddr_w};
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic stall, input logic redir, input logic [29:0] raddr);
        @(posedge CLK);
        #1;
        STALL      = stall;
        REDIR      = redir;
        REDIR_ADDR = raddr;
        @(negedge CLK);
    endtask

    task automatic push_range(input logic [29:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 30'(i));
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_ireq"}, 64'(IREQ), 64'd0);
        checkOutput({tag, "_iaddr"}, 64'(IADDR), 64'd0);
        checkOutput({tag, "_fi_valid"}, 64'(FI_VALID), 64'd0);
        checkOutput({tag, "_fi_instr"}, 64'(FI_INSTR), 64'd0);
        checkOutput({tag, "_fi_iaddr"}, 64'(FI_IADDR), 64'd0);
        checkOutput({tag, "_fi_npc"}, 64'(FI_NPC), 64'd0);
    endtask

    // Monitor: a newly presented IF/ID entry is one that was loaded at the last edge.
    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (FI_VALID) begin
                if (!prev_valid || !prev_stall) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("fi_unexpected_entry", 64'(FI_IADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        logic [29:0] a;
                        a = exp_q.pop_front();
                        checkOutput("fi_entry", {2'b00, FI_IADDR, FI_INSTR},
                                    {2'b00, a, 2'b00, a});
                        checkOutput("fi_npc", 64'(FI_NPC), 64'(a + 30'd1));
                    end
                end
            end else begin
                checkOutput("fi_instr_idle", 64'(FI_INSTR), 64'd0);
            end
            prev_valid = FI_VALID;
            prev_stall = STALL;
        end
    end

    initial begin
        logic stall;
        logic redir;
        logic [29:0] raddr;
        n_total = 0;
        n_pass = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        INSTR = 32'hDEAD_BEEF;
        instr_w = 32'hDEAD_BEEF;
        STALL = 1'b0;
        REDIR = 1'b0;
        REDIR_ADDR = 30'h0;
        stall_w = 1'b0;
        redir_w = 1'b0;
        redir_addr_w = 30'h0;
        RST = 1'b0;
        rst_w = 1'b0;
        #1;
        RST = 1'b1;
        rst_w = 1'b1;
        #2;
        check_reset_values("por");
        checkOutput("wrap_por_iaddr", 64'(iaddr_w), 64'h3FFF_FFFF);

        push_range(30'h0, 11);
        push_range(30'h100, 4);
        push_range(30'h200, 4);
        push_range(30'h0, 4);

        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("c0_ireq", 64'(IREQ), 64'd1);
        checkOutput("c0_iaddr", 64'(IADDR), 64'd0);
        checkOutput("c0_fi_valid", 64'(FI_VALID), 64'd0);

        for (int c = 1; c <= 31; c++) begin
            stall = (c >= 5 && c <= 9) || (c >= 23 && c <= 25) || (c == 31);
            redir = (c == 17) || (c == 25);
            raddr = (c == 17) ? 30'h100 : 30'h200;
            applyStimulus(stall, redir, raddr);
            if (c <= 4) begin
                checkOutput("stream_ireq", 64'(IREQ), 64'd1);
                checkOutput("stream_iaddr", 64'(IADDR), 64'(c));
            end
            case (c)
                2: begin
                    checkOutput("first_fi_valid", 64'(FI_VALID), 64'd1);
                    checkOutput("first_fi_iaddr", 64'(FI_IADDR), 64'd0);
                    checkOutput("first_fi_instr", 64'(FI_INSTR), 64'd0);
                end
                7: begin
                    checkOutput("stall_ireq", 64'(IREQ), 64'd0);
                    checkOutput("stall_iaddr", 64'(IADDR), 64'd6);
                end
                9: begin
                    checkOutput("stall_hold_valid", 64'(FI_VALID), 64'd1);
                    checkOutput("stall_hold_iaddr", 64'(FI_IADDR), 64'd3);
                end
                11: begin
                    checkOutput("resume_ireq", 64'(IREQ), 64'd1);
                    checkOutput("resume_iaddr", 64'(IADDR), 64'd6);
                end
                17: checkOutput("redir_cycle_ireq", 64'(IREQ), 64'd0);
                18: begin
                    checkOutput("redir_fi_valid", 64'(FI_VALID), 64'd0);
                    checkOutput("redir_ireq", 64'(IREQ), 64'd1);
                    checkOutput("redir_iaddr", 64'(IADDR), 64'h100);
                end
                20: checkOutput("redir_target_fi", 64'(FI_IADDR), 64'h100);
                24: checkOutput("full_ireq", 64'(IREQ), 64'd0);
                26: begin
                    checkOutput("stall_redir_fi_valid", 64'(FI_VALID), 64'd0);
                    checkOutput("stall_redir_ireq", 64'(IREQ), 64'd1);
                    checkOutput("stall_redir_iaddr", 64'(IADDR), 64'h200);
                end
                28: checkOutput("stall_redir_target_fi", 64'(FI_IADDR), 64'h200);
                default: ;
            endcase
        end

        // Reset pulse mid-cycle with one buffered entry and one response in flight.
        @(posedge CLK);
        #1;
        STALL = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        check_reset_values("mid_rst");
        STALL = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_restart_ireq", 64'(IREQ), 64'd1);
        checkOutput("rst_restart_iaddr", 64'(IADDR), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, 1'b0, 30'h0);
            if (c == 2) checkOutput("rst_restart_fi", 64'(FI_IADDR), 64'd0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // PC wrap on the second instance.
        @(posedge CLK);
        #1;
        rst_w = 1'b0;
        @(negedge CLK);
        checkOutput("wrap_c0_ireq", 64'(ireq_w), 64'd1);
        checkOutput("wrap_c0_iaddr", 64'(iaddr_w), 64'h3FFF_FFFF);
        @(negedge CLK);
        checkOutput("wrap_c1_iaddr", 64'(iaddr_w), 64'd0);
        @(negedge CLK);
        checkOutput("wrap_c2_iaddr", 64'(iaddr_w), 64'd1);
        checkOutput("wrap_fi_valid", 64'(fi_valid_w), 64'd1);
        checkOutput("wrap_fi_iaddr", 64'(fi_iaddr_w), 64'h3FFF_FFFF);
        checkOutput("wrap_fi_instr", 64'(fi_instr_w), 64'h3FFF_FFFF);
        checkOutput("wrap_fi_npc", 64'(fi_npc_w), 64'd0);
        @(negedge CLK);
        checkOutput("wrap_next_fi_iaddr", 64'(fi_iaddr_w), 64'd0);
        checkOutput("wrap_next_fi_npc", 64'(fi_npc_w), 64'd1);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/risc_toy_fetch.md
# risc_toy_fetch

Instruction-fetch stage for the RISC_TOY 5-stage pipeline. It owns the PC, drives the instruction-memory request port, and fills the IF/ID register consumed by decode. It absorbs decode back-pressure (STALL) with a 2-entry skid buffer and applies taken-branch/jump redirects from EX by flushing everything in flight.

## Interface
- RESET_ADDR, 30'h0000_0000: word address of the first fetch after reset.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IREQ  out  1  instruction-memory request; the read is issued in this cycle.
- IADDR  out  30  word address of the request; equals the PC register.
- INSTR  in  32  read data; valid the cycle after an IREQ cycle (fixed 1-cycle latency).
- STALL  in  1  decode cannot accept; the IF/ID register must hold.
- REDIR  in  1  taken branch/jump from EX; flush and refetch.
- REDIR_ADDR  in  30  redirect target (word address).
- FI_VALID  out  1  IF/ID register holds a live instruction.
- FI_INSTR  out  32  IF/ID instruction.
- FI_IADDR  out  30  IF/ID instruction word address.
- FI_NPC  out  30  FI_IADDR+1 mod 2^30 (link value for BRL/JL).

## Operation
- State: PC (30b), in-flight flag INF plus in-flight address INF_ADDR, skid buffer BUF[0:1] of {instr, addr} with count CNT (0..2), and the IF/ID register.
- Issue rule: IREQ = !RST && !REDIR && (CNT + INF < 2). On issue: INF<=1, INF_ADDR<=PC, PC<=PC+1, wrapping 30'h3FFFFFFF->0. With no issue: INF<=0.
- The issue rule guarantees every response has a slot while STALL persists indefinitely. The IF/ID register plus the 2 buffer entries never overflow.
- Response (INF=1): {INSTR, INF_ADDR} goes directly into IF/ID when IF/ID is free (FI_VALID=0 or STALL=0) and CNT=0. Otherwise it is pushed into BUF.
- IF/ID advance (FI_VALID=0 or STALL=0): load the BUF head if CNT>0, else the response if present, else clear FI_VALID. Strict FIFO order; no loss, no duplication.
- Simultaneous pop and push in one cycle: CNT is unchanged and the pushed entry goes behind the remaining one.
- STALL=1 with FI_VALID=1: IF/ID is frozen. Responses fill BUF and issue stops once CNT+INF reaches 2.
- REDIR (priority over STALL and everything else):
  - PC<=REDIR_ADDR, CNT<=0, INF<=0 (the next-cycle INSTR is discarded).
  - FI_VALID<=0, FI_INSTR<=0.
  - No IREQ in the redirect cycle.
- While FI_VALID=0, FI_INSTR is 32'h0. Decode gates on FI_VALID; it does not rely on the encoding, since 0 decodes as ADDI.

## Timing
- Reset values (asynchronous, immediate): IREQ=0, PC=RESET_ADDR (so IADDR=RESET_ADDR), INF=0, CNT=0, FI_VALID=0, FI_INSTR=0, FI_IADDR=0, FI_NPC=0.
- First IREQ is in the first cycle with RST low. An INSTR that arrives after reset deassertion, belonging to a pre-reset request, is ignored because INF=0.
- Fetch latency: IREQ in cycle n -> FI_VALID with that instruction in cycle n+2.
- Steady throughput: 1 instruction/cycle with STALL=0.
- Redirect in cycle r:
  - FI_VALID=0 in r+1.
  - IREQ=1 with IADDR=target in r+1.
  - Target visible at FI in r+3.
  - 2 bubbles minimum.
- STALL release in cycle s (STALL=0): FI advances at the end of s. Buffered entries drain one per cycle before new responses, and IREQ resumes in the same cycle that CNT+INF drops below 2.
- REDIR and STALL together: the redirect wins; FI is cleared despite STALL.
- RST asserted mid-operation: all state is cleared asynchronously, and no partial update of FI survives.

## Test plan
- Reset release, RESET_ADDR=0, memory returns INSTR={2'b0,addr}:
  - IADDR=0,1,2,... with IREQ=1 every cycle from cycle 0.
  - FI_IADDR=0 with FI_INSTR=0 at cycle 2, then +1 per cycle.
  - FI_NPC=FI_IADDR+1.
- STALL high for 5 cycles while FI_IADDR=3:
  - FI holds 3; exactly addresses 4,5 are buffered and IREQ=0 with IADDR=6.
  - After release, FI shows 4,5,6,7... on consecutive cycles with no gap or duplicate.
- REDIR with REDIR_ADDR=30'h100 at cycle r while streaming:
  - FI_VALID=0 at r+1, and the INSTR from the r-1 request is dropped.
  - IREQ with IADDR=30'h100 at r+1, and FI_IADDR=30'h100 at r+3.
- REDIR while STALL=1 and CNT=2:
  - FI_VALID=0, CNT=0 next cycle.
  - The first instruction after the flush comes from REDIR_ADDR; no buffered entry ever reappears.
- Wrap, RESET_ADDR=30'h3FFFFFFF: IADDR sequence is 3FFFFFFF, 0, 1; FI_NPC=0 when FI_IADDR=3FFFFFFF.
- RST pulse mid-cycle with INF=1 and CNT=1:
  - Outputs go to reset values before the next edge.
  - After release, fetch restarts at RESET_ADDR, and the stale INSTR presented in the release cycle never reaches FI.
